seq_sub40_22: RTL

- Multi-cycle inverse of the 39+22-bit unsigned accumulate stage in the multiplier datapath.
- Takes a 40-bit sum and a 22-bit addend, then recovers the 39-bit operand: diff = sum - zero_ext(addend).
- Processes CHUNK bits per cycle using a borrow chain.
- Uses a valid/ready handshake on both sides. It sits in the checker/undo path after the partial-product accumulator.

---
 rtl/seq_sub40_22_pkg.sv | 29 ++
 rtl/seq_sub40_22_if.sv | 38 +++
 rtl/seq_sub40_22_sub_chunk_borrow.sv | 25 ++
 rtl/seq_sub40_22.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_sub40_22_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_sub40_22_pkg
// Brief    : Shared widths, chunk count helper and FSM state encoding for the
//            sequential 40-bit minus 22-bit borrow-chain subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package seq_sub40_22_pkg;

    // Default operand widths and chunk size.
    localparam int c_S_W   = 40;
    localparam int c_B_W   = 22;
    localparam int c_CHUNK = 8;

    // Number of CHUNK-bit slices needed to cover a W-bit operand.
    function automatic int calc_nchunk(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

    localparam int c_NCHUNK = calc_nchunk(c_S_W, c_CHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_sub40_22_pkg
`default_nettype wire

// File: rtl/seq_sub40_22_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_sub40_22_if
// Brief    : Operand/result valid-ready bundle for seq_sub40_22. The master
//            side drives operands and accepts results; the slave is the
//            subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_sub40_22_if
    import seq_sub40_22_pkg::*;
#(
    parameter int S_W = c_S_W,
    parameter int B_W = c_B_W
);
    logic           in_valid;
    logic           in_ready;
    logic [S_W-1:0] in_sum;
    logic [B_W-1:0] in_b;
    logic           out_valid;
    logic           out_ready;
    logic [S_W-2:0] out_diff;
    logic           out_underflow;
    logic           out_range_err;
    logic [2:0]     out_cycles;

    modport master (
        output in_valid, in_sum, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_underflow, out_range_err,
               out_cycles
    );

    modport slave (
        input  in_valid, in_sum, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_underflow, out_range_err,
               out_cycles
    );
endinterface : seq_sub40_22_if
`default_nettype wire

// File: rtl/seq_sub40_22_sub_chunk_borrow.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk_borrow
// Brief    : Combinational W-bit slice computing a - b - bin with borrow out.
//            A partial top slice is handled by zero-padding both operands;
//            the borrow then ripples through the padding unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunk_borrow #(
    parameter int W = 8
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic         i_bin,
    output logic      [W-1:0] o_diff,
    output logic              o_bout
);
    logic [W:0] w_full;

    // One extra bit captures the borrow as the sign of the widened difference.
    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
    assign o_diff = w_full[W-1:0];
    assign o_bout = w_full[W];
endmodule : sub_chunk_borrow
`default_nettype wire

// File: rtl/seq_sub40_22.sv
`default_nettype none
// ============================================================================
// Module   : seq_sub40_22
// Brief    : Multi-cycle sum - zero_ext(addend), CHUNK bits per cycle through
//            a registered borrow chain, with valid/ready on both sides.
//            Optional macro SEQ_SUB_EARLY_TERM_EN: once the chunk holding the
//            addend MSB produces no borrow, the remaining chunks are copied
//            from the sum and the result completes early.
// Revision : 1.0 - initial release
// ============================================================================
module seq_sub40_22
    import seq_sub40_22_pkg::*;
#(
    parameter int S_W   = c_S_W,
    parameter int B_W   = c_B_W,
    parameter int CHUNK = c_CHUNK
) (
    input wire logic      clk,
    input wire logic      rst,
    seq_sub40_22_if.slave bus
);
    localparam int c_NCH   = calc_nchunk(S_W, CHUNK);
    localparam int c_PW    = c_NCH * CHUNK;
    localparam int c_IDX_W = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_in_ready;
    logic                w_out_valid;

    logic [c_PW-1:0]     r_sum;
    logic [c_PW-1:0]     r_b;
    logic [c_PW-1:0]     r_diff;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_borrow;
    logic [2:0]          r_cycles;

    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK-1:0]    w_chunk_diff;
    logic                w_bout;
    logic                w_run_end;

`ifdef SEQ_SUB_EARLY_TERM_EN
    localparam int c_B_CHUNK = (B_W - 1) / CHUNK;
    logic w_early;
    // Above the addend MSB the subtrahend is zero, so no borrow means done.
    assign w_early   = (r_idx == c_IDX_W'(c_B_CHUNK)) && !w_bout;
    assign w_run_end = (r_idx == c_LAST) || w_early;
`else
    assign w_run_end = (r_idx == c_LAST);
`endif

    // Select the current chunk of both operands.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < c_NCH; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_a_chunk = r_sum[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    sub_chunk_borrow #(
        .W (CHUNK)
    ) u_slice (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_bin  (r_borrow),
        .o_diff (w_chunk_diff),
        .o_bout (w_bout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_end) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture and one borrow-chain step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum    <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_cycles <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sum    <= c_PW'(bus.in_sum);
                        r_b      <= c_PW'(bus.in_b);
                        r_diff   <= '0;
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        r_cycles <= 3'd0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < c_NCH; k++) begin
                        if (r_idx == c_IDX_W'(k))
                            r_diff[k*CHUNK +: CHUNK] <= w_chunk_diff;
                    end
`ifdef SEQ_SUB_EARLY_TERM_EN
                    if (w_early) begin
                        for (int k = c_B_CHUNK + 1; k < c_NCH; k++)
                            r_diff[k*CHUNK +: CHUNK] <= r_sum[k*CHUNK +: CHUNK];
                    end
`endif
                    r_borrow <= w_bout;
                    r_idx    <= r_idx + 1'b1;
                    r_cycles <= r_cycles + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_diff      = r_diff[S_W-2:0];
    assign bus.out_underflow = r_borrow;
    assign bus.out_range_err = ~r_borrow & r_diff[S_W-1];
    assign bus.out_cycles    = r_cycles;

endmodule : seq_sub40_22
`default_nettype wire
